// File: rtl/ex_stage_hazard_controller_pkg.sv
// ex_stage_hazard_controller_pkg: pipeline state type and opcode/func7 constants shared by the hazard controller
package riscv_pipe_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
endpackage

// File: rtl/ex_stage_hazard_controller_if.sv
// ex_stage_hazard_controller_if: pipeline<->hazard controller bus; master = pipeline, slave = controller; perf ports under HAZARD_PERF_CNT_EN
interface ex_stage_hazard_controller_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [6:0] ex_opcode;
  logic [6:0] ex_func7;
  logic [2:0] ex_func3;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       md_done;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       md_start;
  logic       md_busy;
  logic       md_error;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_events;
`endif
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_opcode, ex_func7, ex_func3, ex_rd,
           ex_branch_taken, md_done,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_stall_cycles, perf_flush_events,
`endif
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, md_start, md_busy, md_error
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_opcode, ex_func7, ex_func3, ex_rd,
           ex_branch_taken, md_done,
`ifdef HAZARD_PERF_CNT_EN
    output perf_stall_cycles, perf_flush_events,
`endif
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, md_start, md_busy, md_error
  );
endinterface

// File: rtl/ex_stage_hazard_controller_load_use_detect.sv
// load_use_detect: combinational load-use compare of EX load destination against ID sources (i_* operands, o_lu result)
module load_use_detect (
  input  logic       i_is_load,
  input  logic [4:0] i_ex_rd,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_uses_rs1,
  input  logic       i_uses_rs2,
  output logic       o_lu
);
  assign o_lu = i_is_load && (i_ex_rd != 5'd0) &&
                ((i_uses_rs1 && i_id_rs1 == i_ex_rd) || (i_uses_rs2 && i_id_rs2 == i_ex_rd));
endmodule

// File: rtl/ex_stage_hazard_controller.sv
// ex_stage_hazard_controller: stall/flush sequencer (clk, async active-low rst, bus slave modport); optional HAZARD_PERF_CNT_EN perf counters
module ex_stage_hazard_controller
  import riscv_pipe_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int TO_W       = 16
) (
  input  logic clk,
  input  logic rst,
  ex_stage_hazard_controller_if.slave bus
);
  state_t          r_state;
  logic [TO_W-1:0] r_cnt;
  logic            r_err;
  logic w_is_load, w_is_div, w_lu, w_busy, w_to, w_rel, w_hold, w_br, w_lu_act;
  logic w_unused;
  assign w_unused  = ^bus.ex_func3[1:0];
  assign w_is_load = bus.ex_opcode == OPC_LOAD;
  assign w_is_div  = bus.ex_opcode == OPC_RTYPE && bus.ex_func7 == F7_MULDIV && bus.ex_func3[2];
  load_use_detect u_lu (
    .i_is_load (w_is_load),
    .i_ex_rd   (bus.ex_rd),
    .i_id_rs1  (bus.id_rs1),
    .i_id_rs2  (bus.id_rs2),
    .i_uses_rs1(bus.id_uses_rs1),
    .i_uses_rs2(bus.id_uses_rs2),
    .o_lu      (w_lu)
  );
  assign w_busy   = r_state == MD_BUSY;
  assign w_to     = r_cnt == TO_W'(MD_TIMEOUT - 1);
  // release (done or timeout) drops the stall in the same cycle so ID/EX advances on that edge
  assign w_rel    = w_busy && (bus.md_done || w_to);
  // outputs are gated by rst so everything reads 0 while reset is held
  assign w_hold   = rst && ((w_busy && !w_rel) || (!w_busy && w_is_div));
  assign w_br     = rst && !w_hold && bus.ex_branch_taken;
  assign w_lu_act = rst && !w_hold && !bus.ex_branch_taken && w_lu;
  assign bus.pc_stall    = w_hold || w_lu_act;
  assign bus.if_id_stall = w_hold || w_lu_act;
  assign bus.if_id_flush = w_br;
  assign bus.id_ex_stall = w_hold;
  assign bus.id_ex_flush = w_br || w_lu_act;
  assign bus.md_start    = rst && !w_busy && w_is_div;
  assign bus.md_busy     = rst && w_busy;
  assign bus.md_error    = r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_busy ? (w_rel ? IDLE : MD_BUSY) : (w_is_div ? MD_BUSY : IDLE);
      r_cnt   <= w_busy ? r_cnt + 1'b1 : '0;
      r_err   <= r_err || (w_busy && !bus.md_done && w_to);
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(bus.pc_stall);
      r_flush_cnt <= r_flush_cnt + 32'(bus.if_id_flush);
    end
  end
  assign bus.perf_stall_cycles = r_stall_cnt;
  assign bus.perf_flush_events = r_flush_cnt;
`endif
endmodule

// File: tb/tb_ex_stage_hazard_controller.sv
// tb_ex_stage_hazard_controller: directed self-checking bench for the hazard controller
module tb_ex_stage_hazard_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ex_stage_hazard_controller_if bus ();
  ex_stage_hazard_controller_if bus_t ();
  ex_stage_hazard_controller #(.MD_TIMEOUT(64), .TO_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  ex_stage_hazard_controller #(.MD_TIMEOUT(8), .TO_W(16)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));
  assign bus_t.id_rs1          = bus.id_rs1;
  assign bus_t.id_rs2          = bus.id_rs2;
  assign bus_t.id_uses_rs1     = bus.id_uses_rs1;
  assign bus_t.id_uses_rs2     = bus.id_uses_rs2;
  assign bus_t.ex_opcode       = bus.ex_opcode;
  assign bus_t.ex_func7        = bus.ex_func7;
  assign bus_t.ex_func3        = bus.ex_func3;
  assign bus_t.ex_rd           = bus.ex_rd;
  assign bus_t.ex_branch_taken = bus.ex_branch_taken;
  assign bus_t.md_done         = bus.md_done;
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, md_start, md_busy, md_error}
  logic [7:0] obs, obs_t;
  assign obs   = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
                  bus.id_ex_flush, bus.md_start, bus.md_busy, bus.md_error};
  assign obs_t = {bus_t.pc_stall, bus_t.if_id_stall, bus_t.if_id_flush, bus_t.id_ex_stall,
                  bus_t.id_ex_flush, bus_t.md_start, bus_t.md_busy, bus_t.md_error};
  localparam logic [7:0] NONE = 8'h00, LU = 8'hC8, BR = 8'h28, START = 8'hD4, BUSY = 8'hD2, REL = 8'h02;
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_opcode = 0; bus.ex_func7 = 0; bus.ex_func3 = 0; bus.ex_rd = 0;
    bus.ex_branch_taken = 0; bus.md_done = 0;
  endtask
  task automatic set_ex(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    bus.ex_opcode = op; bus.ex_func7 = f7; bus.ex_func3 = f3; bus.ex_rd = rd;
  endtask
  initial begin
    clr();
    set_ex(7'b0110011, 7'b0000001, 3'b100, 5'd3);
    tick(); chk("reset_outputs_zero", obs, NONE);
    clr(); rst = 1'b1;
    #1 chk("idle_after_reset", obs, NONE);
    tick(); set_ex(7'b0000011, 0, 3'b010, 5'd5); bus.id_rs1 = 5; bus.id_uses_rs1 = 1;
    #1 chk("lu_rs1", obs, LU);
    tick(); clr();
    #1 chk("lu_one_bubble_only", obs, NONE);
    tick(); set_ex(7'b0000011, 0, 3'b010, 5'd0); bus.id_rs1 = 0; bus.id_uses_rs1 = 1;
    #1 chk("lu_rd_zero", obs, NONE);
    tick(); clr(); set_ex(7'b0000011, 0, 3'b010, 5'd7); bus.id_rs2 = 7; bus.id_uses_rs2 = 1;
    #1 chk("lu_rs2", obs, LU);
    bus.id_uses_rs2 = 0; bus.id_rs1 = 7;
    #1 chk("lu_unused_src", obs, NONE);
    bus.id_uses_rs1 = 1; bus.ex_branch_taken = 1;
    #1 chk("branch_over_lu", obs, BR);
    tick(); clr(); bus.ex_branch_taken = 1;
    #1 chk("branch_only", obs, BR);
    tick(); clr(); set_ex(7'b0110011, 7'b0000001, 3'b000, 5'd4);
    #1 chk("mul_no_stall", obs, NONE);
    bus.ex_opcode = 7'b0000000; bus.md_done = 1;
    #1 chk("done_in_idle", obs, NONE);
    tick(); bus.md_done = 0;
    #1 chk("done_in_idle_ignored", obs, NONE);
    set_ex(7'b0110011, 7'b0000001, 3'b100, 5'd4);
    #1 chk("div_start", obs, START);
    for (int k = 1; k <= 9; k++) begin
      tick(); chk("div_busy", obs, BUSY);
    end
    tick(); bus.md_done = 1;
    #1 chk("div_release", obs, REL);
    tick(); clr();
    #1 chk("div_back_idle", obs, NONE);
    set_ex(7'b0110011, 7'b0000001, 3'b101, 5'd6);
    #1 chk("b2b_first_start", obs, START);
    tick(); chk("b2b_busy1", obs, BUSY);
    tick(); bus.md_done = 1;
    #1 chk("b2b_release_no_start", obs, REL);
    tick(); bus.md_done = 0;
    #1 chk("b2b_second_start", obs, START);
    tick(); chk("b2b_second_busy", obs, BUSY);
    tick(); bus.md_done = 1;
    #1 chk("b2b_second_release", obs, REL);
    tick(); clr();
    #1 chk("b2b_idle", obs, NONE);
    set_ex(7'b0110011, 7'b0000001, 3'b110, 5'd2);
    #1 chk("rstmid_start", obs, START);
    tick(); tick(); tick(); chk("rstmid_busy3", obs, BUSY);
    rst = 1'b0;
    #1 chk("rstmid_async_zero", obs, NONE);
    tick(); rst = 1'b1;
    #1 chk("rstmid_restart", obs, START);
    tick(); bus.md_done = 1;
    #1 chk("rstmid_release", obs, REL);
    tick(); clr();
    rst = 1'b0; tick(); rst = 1'b1;
    #1 chk("to_reset_clean", obs_t, NONE);
    set_ex(7'b0110011, 7'b0000001, 3'b111, 5'd9);
    #1 chk("to_start", obs_t, START);
    for (int k = 1; k <= 7; k++) begin
      tick(); chk("to_busy", obs_t, BUSY);
    end
    tick(); chk("to_release_8th", obs_t, REL);
    chk("to_long_timeout_still_busy", obs, BUSY);
    tick(); clr();
    #1 chk("to_error_set", obs_t, 8'h01);
    tick(); set_ex(7'b0000011, 0, 3'b010, 5'd5); bus.id_rs1 = 5; bus.id_uses_rs1 = 1;
    #1 chk("to_error_sticky", obs_t, 8'hC9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
